// File: rtl/sample_sched_pkg.sv
// Shared types and default widths for the sample burst scheduler.
package sample_sched_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 16;
  localparam int unsigned DEFAULT_LEN_WIDTH  = 16;
  localparam int unsigned DEFAULT_CNT_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

endpackage : sample_sched_pkg

// File: rtl/sample_burst_scheduler.sv
// Frames a free-running sample stream into N bursts of L samples separated
// by G discarded samples, with first/last markers and start/abort control.
module sample_burst_scheduler
  import sample_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = DEFAULT_LEN_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic [LEN_WIDTH-1:0]         burst_len,
  input  logic [LEN_WIDTH-1:0]         gap_len,
  input  logic [CNT_WIDTH-1:0]         num_bursts,
  input  logic signed [DATA_WIDTH-1:0] s_data,
  input  logic                         s_valid,
  output logic signed [DATA_WIDTH-1:0] m_data,
  output logic                         m_valid,
  output logic                         m_first,
  output logic                         m_last,
  output logic [CNT_WIDTH-1:0]         burst_idx,
  output logic                         busy,
  output logic                         done,
  output logic                         err_cfg
);

  sched_state_t         state;
  logic [LEN_WIDTH-1:0] cfg_len;
  logic [LEN_WIDTH-1:0] cfg_gap;
  logic [CNT_WIDTH-1:0] cfg_num;
  logic [LEN_WIDTH-1:0] sample_cnt;
  logic [LEN_WIDTH-1:0] gap_cnt;
  logic [CNT_WIDTH-1:0] burst_cnt;

  logic last_sample_c;
  logic final_burst_c;
  logic gap_end_c;

  // Position decodes against the latched configuration.
  always_comb begin
    last_sample_c = (sample_cnt == cfg_len - LEN_WIDTH'(1));
    final_burst_c = (cfg_num != '0) && (burst_cnt == cfg_num - CNT_WIDTH'(1));
    gap_end_c     = (gap_cnt == cfg_gap - LEN_WIDTH'(1));
  end

  // Scheduler FSM, counters and registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cfg_len    <= '0;
      cfg_gap    <= '0;
      cfg_num    <= '0;
      sample_cnt <= '0;
      gap_cnt    <= '0;
      burst_cnt  <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_first    <= 1'b0;
      m_last     <= 1'b0;
      burst_idx  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_cfg    <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      m_first <= 1'b0;
      m_last  <= 1'b0;
      done    <= 1'b0;
      err_cfg <= 1'b0;

      if (abort) begin
        // Abort wins over everything; in IDLE it simply masks start.
        if (state != IDLE) begin
          state      <= IDLE;
          busy       <= 1'b0;
          sample_cnt <= '0;
          gap_cnt    <= '0;
          burst_cnt  <= '0;
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              if (burst_len == '0) begin
                err_cfg <= 1'b1;
              end else begin
                cfg_len    <= burst_len;
                cfg_gap    <= gap_len;
                cfg_num    <= num_bursts;
                sample_cnt <= '0;
                gap_cnt    <= '0;
                burst_cnt  <= '0;
                busy       <= 1'b1;
                state      <= BURST;
              end
            end
          end

          BURST: begin
            if (s_valid) begin
              m_data    <= s_data;
              m_valid   <= 1'b1;
              m_first   <= (sample_cnt == '0);
              m_last    <= last_sample_c;
              burst_idx <= burst_cnt;
              if (last_sample_c) begin
                sample_cnt <= '0;
                if (final_burst_c) begin
                  state <= DONE;
                end else if (cfg_gap == '0) begin
                  burst_cnt <= burst_cnt + CNT_WIDTH'(1);
                end else begin
                  gap_cnt <= '0;
                  state   <= GAP;
                end
              end else begin
                sample_cnt <= sample_cnt + LEN_WIDTH'(1);
              end
            end
          end

          GAP: begin
            if (s_valid) begin
              if (gap_end_c) begin
                gap_cnt   <= '0;
                burst_cnt <= burst_cnt + CNT_WIDTH'(1);
                state     <= BURST;
              end else begin
                gap_cnt <= gap_cnt + LEN_WIDTH'(1);
              end
            end
          end

          DONE: begin
            done      <= 1'b1;
            busy      <= 1'b0;
            burst_cnt <= '0;
            state     <= IDLE;
          end

          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule : sample_burst_scheduler

// File: doc/sample_burst_scheduler.md
Name: sample_burst_scheduler

Overview:
- Sequences a free-running sample stream (data + valid, no backpressure) into scheduled bursts.
- A start pulse launches N bursts of L samples, each separated by G discarded samples.
- Sits between a sample source (ADC model, file-driven stimulus, DDS) and a consumer that needs framed bursts with first/last markers.
- Software-style control: start, abort, busy, done.

Parameters:
- DATA_WIDTH, 16, sample width in bits (signed).
- LEN_WIDTH, 16, width of burst_len and gap_len.
- CNT_WIDTH, 8, width of num_bursts and burst_idx.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; latches config and begins schedule (only honoured in IDLE).
- abort  in  1  level/pulse; terminates schedule immediately.
- burst_len  in  LEN_WIDTH  samples per burst; 0 is illegal.
- gap_len  in  LEN_WIDTH  valid input samples discarded between bursts; 0 means back-to-back bursts.
- num_bursts  in  CNT_WIDTH  bursts to emit; 0 means continuous until abort.
- s_data  in  DATA_WIDTH  signed input sample.
- s_valid  in  1  input sample qualifier.
- m_data  out  DATA_WIDTH  forwarded sample (registered).
- m_valid  out  1  forwarded sample qualifier.
- m_first  out  1  high with first sample of each burst.
- m_last  out  1  high with last sample of each burst.
- burst_idx  out  CNT_WIDTH  index of current burst, 0-based.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last sample of the final burst.
- err_cfg  out  1  one-cycle pulse when start is seen with burst_len==0.

Behaviour:
- Reset values: all outputs 0. State IDLE, all counters 0, latched config 0.
- Config (burst_len, gap_len, num_bursts) is latched on start in IDLE. Input changes after that have no effect until the next start.
- Counters advance only on cycles with s_valid=1. Idle input cycles hold all state.
- Latency: fixed 1 cycle from s_data/s_valid to m_data/m_valid. m_data updates only when a sample is forwarded; otherwise it holds its last value.

State machine:
- IDLE:
  - start with burst_len==0 → err_cfg=1 for 1 cycle, stay IDLE.
  - start with burst_len!=0 → BURST; sample_cnt=0, burst_cnt=0.
  - start with busy=1 is ignored (no error).
- BURST: each s_valid forwards the sample.
  - m_first when sample_cnt==0.
  - m_last when sample_cnt==burst_len-1.
  - On the last sample:
    - If final burst (burst_cnt==num_bursts-1, num_bursts!=0) → DONE.
    - Else if gap_len==0 → stay in BURST with burst_cnt+1.
    - Else → GAP with gap_cnt=0.
  - burst_len==1 gives m_first and m_last on the same sample.
- GAP: each s_valid is discarded (m_valid=0) and gap_cnt increments. When gap_cnt reaches gap_len-1 on a valid sample → BURST with burst_cnt+1. The next valid sample is the burst's first.
- DONE: done=1 for exactly 1 cycle (the cycle after m_last of the final burst is registered), then IDLE. Input samples in this cycle are dropped.

Boundary conditions:
- Continuous mode (num_bursts==0): burst_cnt wraps modulo 2^CNT_WIDTH, never reaches DONE, burst_idx wraps 2^CNT_WIDTH-1 → 0.
- Abort: highest priority over everything except rst, in any non-IDLE state.
  - Next state is IDLE; the sample in the abort cycle is not forwarded.
  - m_valid/m_first/m_last deassert the following cycle; done is not pulsed.
- Abort and start in the same cycle in IDLE: abort wins and start is ignored.
- rst mid-burst returns to the reset state in one cycle with no done pulse. The burst is truncated without m_last.
- burst_idx reflects burst_cnt and is registered alongside m_data.

Decomposition:
- Package sample_sched_pkg:
  - typedef enum logic [1:0] sched_state_t {IDLE, BURST, GAP, DONE}.
  - Localparam defaults for DATA_WIDTH, LEN_WIDTH and CNT_WIDTH.
- No sub-module. The three counters (sample_cnt, gap_cnt, burst_cnt) and the FSM live in one module.
- Output register stage is inline.

Test Plan:
- Basic run: burst_len=4, gap_len=2, num_bursts=3, s_valid always 1, ramp data 0,1,2,…
  → bursts {0-3},{6-9},{12-15}; m_first on 0,6,12; m_last on 3,9,15; burst_idx 0,1,2; done pulses once, 1 cycle after 15 is output; busy then low.
- Sparse valid: the same config with s_valid toggling 1,0,1,0
  → identical forwarded sample values and markers, spread over twice the cycles; no sample dropped or duplicated.
- Edges: burst_len=1, gap_len=0, num_bursts=2
  → two consecutive samples, each with m_first=m_last=1, done pulse.
- Illegal config: start with burst_len=0 → err_cfg pulse, busy stays 0. Then start during BURST → ignored, schedule unchanged.
- Continuous mode and abort: num_bursts=0, burst_len=2, gap_len=0, CNT_WIDTH=2; run 5 bursts
  → burst_idx 0,1,2,3,0. Assert abort mid-burst → m_valid low next cycle, no done, busy low.
- Reset mid-operation: assert rst during GAP → all outputs 0 next cycle. A new start then runs cleanly from burst_idx 0.
